// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter with round-robin grant
// and an in-order ID FIFO that routes responses back to their issuer.
module mem_arbiter #(
  parameter int OutstandingLog2 = 2,
  parameter int AddrWidth       = 32,
  parameter int DataWidth       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   inst_valid_i,
  output logic                   inst_ready_o,
  input  logic [AddrWidth-1:0]   inst_addr_i,
  input  logic [DataWidth-1:0]   inst_wdata_i,
  input  logic [DataWidth/8-1:0] inst_wmask_i,
  output logic [DataWidth-1:0]   inst_rdata_o,
  output logic                   inst_rvalid_o,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  input  logic [DataWidth/8-1:0] data_wmask_i,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_rvalid_o,
  input  logic                   mem_ready_i,
  output logic                   mem_valid_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_wmask_o,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_rvalid_i,
  output logic                   err_o
);

  localparam int Depth = 1 << OutstandingLog2;
  localparam int PW    = OutstandingLog2 + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [Depth-1:0] ids_q, ids_d;
  logic             rr_q, rr_d;
  logic             err_q, err_d;

  logic fifo_empty;
  logic fifo_full;
  logic head_id;
  logic gnt_inst;
  logic gnt_data;
  logic req_ok;
  logic accept;
  logic pop;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                      (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
  assign head_id    = ids_q[rptr_q[PW-2:0]];

  // rr_q holds the ID of the last accepted master; contention goes to the other.
  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    unique case (1'b1)
      (inst_valid_i && data_valid_i): begin
        gnt_inst = rr_q;
        gnt_data = !rr_q;
      end
      (inst_valid_i && !data_valid_i): gnt_inst = 1'b1;
      (!inst_valid_i && data_valid_i): gnt_data = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    unique case (1'b1)
      gnt_inst: begin
        mem_addr_o  = inst_addr_i;
        mem_wdata_o = inst_wdata_i;
        mem_wmask_o = inst_wmask_i;
      end
      gnt_data: begin
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
        mem_wmask_o = data_wmask_i;
      end
      default: ;
    endcase
  end

  // Full blocks forwarding even if a pop lands this cycle: no rvalid->ready path.
  assign req_ok       = rst_ni && !fifo_full;
  assign mem_valid_o  = req_ok && (inst_valid_i || data_valid_i);
  assign inst_ready_o = req_ok && gnt_inst && mem_ready_i;
  assign data_ready_o = req_ok && gnt_data && mem_ready_i;
  assign accept       = mem_valid_o && mem_ready_i;

  assign pop           = rst_ni && mem_rvalid_i && !fifo_empty;
  assign inst_rvalid_o = pop && !head_id;
  assign data_rvalid_o = pop && head_id;
  assign inst_rdata_o  = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign err_o         = err_q;

  always_comb begin
    ids_d  = ids_q;
    wptr_d = wptr_q + {{(PW-1){1'b0}}, accept};
    rptr_d = rptr_q + {{(PW-1){1'b0}}, pop};
    rr_d   = rr_q;
    err_d  = err_q;
    if (accept) begin
      ids_d[wptr_q[PW-2:0]] = gnt_data;
      rr_d                  = gnt_data;
    end
    if (mem_rvalid_i && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ids_q  <= '0;
      rr_q   <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ids_q  <= ids_d;
      rr_q   <= rr_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: grant order, FIFO-full
// boundary, in-order response routing, stray responses and reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        inst_valid_i, inst_ready_o;
  logic [31:0] inst_addr_i, inst_wdata_i, inst_rdata_o;
  logic [3:0]  inst_wmask_i;
  logic        inst_rvalid_o;
  logic        data_valid_i, data_ready_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_wmask_i;
  logic        data_rvalid_o;
  logic        mem_ready_i, mem_valid_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wmask_o;
  logic        mem_rvalid_i;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .OutstandingLog2(2),
    .AddrWidth(32),
    .DataWidth(32)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o),
    .inst_addr_i(inst_addr_i),
    .inst_wdata_i(inst_wdata_i),
    .inst_wmask_i(inst_wmask_i),
    .inst_rdata_o(inst_rdata_o),
    .inst_rvalid_o(inst_rvalid_o),
    .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o),
    .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i),
    .data_wmask_i(data_wmask_i),
    .data_rdata_o(data_rdata_o),
    .data_rvalid_o(data_rvalid_o),
    .mem_ready_i(mem_ready_i),
    .mem_valid_o(mem_valid_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i),
    .err_o(err_o)
  );

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [3:0]  dm;
    logic        mr;
    logic        rv;
    logic [31:0] rd;
    logic        mv;
    logic        ca;
    logic [31:0] ma;
    logic [3:0]  mm;
    logic        ir;
    logic        dr;
    logic        irv;
    logic        drv;
    logic        er;
  } vec_t;

  vec_t tbl[31];

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic idle();
    inst_valid_i = 0; inst_addr_i = 0; inst_wdata_i = 0; inst_wmask_i = 0;
    data_valid_i = 0; data_addr_i = 0; data_wdata_i = 0; data_wmask_i = 0;
    mem_ready_i  = 1; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  initial begin
    // iv ia dv da dm mr rv rd | mv ca ma mm ir dr irv drv er
    tbl[0]  = '{1,'h100,1,'h200,0,1,0,0,     1,1,'h100,0,1,0,0,0,0};
    tbl[1]  = '{1,'h104,1,'h204,0,1,1,'h11,  1,1,'h204,0,0,1,1,0,0};
    tbl[2]  = '{1,'h108,1,'h208,0,1,1,'h22,  1,1,'h108,0,1,0,0,1,0};
    tbl[3]  = '{1,'h10c,1,'h20c,'hf,1,1,'h33,1,1,'h20c,'hf,0,1,1,0,0};
    tbl[4]  = '{0,0,0,0,0,1,1,'h44,          0,1,0,0,0,0,0,1,0};
    tbl[5]  = '{1,'h0,0,0,0,1,0,0,           1,1,'h0,0,1,0,0,0,0};
    tbl[6]  = '{1,'h4,0,0,0,1,1,'ha,         1,1,'h4,0,1,0,1,0,0};
    tbl[7]  = '{1,'h8,0,0,0,1,1,'hb,         1,1,'h8,0,1,0,1,0,0};
    tbl[8]  = '{1,'hc,0,0,0,1,1,'hc,         1,1,'hc,0,1,0,1,0,0};
    tbl[9]  = '{0,0,0,0,0,1,1,'hd,           0,1,0,0,0,0,1,0,0};
    tbl[10] = '{0,0,1,'h300,0,0,0,0,         1,1,'h300,0,0,0,0,0,0};
    tbl[11] = '{0,0,1,'h300,0,1,0,0,         1,1,'h300,0,0,1,0,0,0};
    tbl[12] = '{0,0,1,'h304,0,1,0,0,         1,1,'h304,0,0,1,0,0,0};
    tbl[13] = '{0,0,1,'h308,0,1,0,0,         1,1,'h308,0,0,1,0,0,0};
    tbl[14] = '{0,0,1,'h30c,0,1,0,0,         1,1,'h30c,0,0,1,0,0,0};
    tbl[15] = '{1,'h40,1,'h310,0,1,0,0,      0,0,0,0,0,0,0,0,0};
    tbl[16] = '{1,'h40,1,'h310,0,1,1,'h55,   0,0,0,0,0,0,0,1,0};
    tbl[17] = '{1,'h40,1,'h310,0,1,0,0,      1,1,'h40,0,1,0,0,0,0};
    tbl[18] = '{0,0,0,0,0,1,1,'h56,          0,1,0,0,0,0,0,1,0};
    tbl[19] = '{0,0,0,0,0,1,1,'h57,          0,1,0,0,0,0,0,1,0};
    tbl[20] = '{0,0,0,0,0,1,1,'h58,          0,1,0,0,0,0,0,1,0};
    tbl[21] = '{0,0,0,0,0,1,1,'h59,          0,1,0,0,0,0,1,0,0};
    tbl[22] = '{1,'h80,0,0,0,1,0,0,          1,1,'h80,0,1,0,0,0,0};
    tbl[23] = '{0,0,1,'h90,'h3,1,1,'h66,     1,1,'h90,'h3,0,1,1,0,0};
    tbl[24] = '{0,0,0,0,0,1,1,'h77,          0,1,0,0,0,0,0,1,0};
    tbl[25] = '{0,0,0,0,0,1,1,'h88,          0,1,0,0,0,0,0,0,0};
    tbl[26] = '{0,0,0,0,0,1,0,0,             0,1,0,0,0,0,0,0,1};
    tbl[27] = '{1,'ha0,0,0,0,1,0,0,          1,1,'ha0,0,1,0,0,0,1};
    tbl[28] = '{0,0,0,0,0,1,1,'h99,          0,1,0,0,0,0,1,0,1};
    tbl[29] = '{1,'hb0,0,0,0,1,1,'haa,       1,1,'hb0,0,1,0,0,0,1};
    tbl[30] = '{0,0,0,0,0,1,1,'hbb,          0,1,0,0,0,0,1,0,1};

    idle();
    rst_ni = 0;
    inst_valid_i = 1;
    data_valid_i = 1;
    mem_rvalid_i = 1;
    @(negedge clk);
    #1;
    chk("rst_mem_valid", -1, 32'(mem_valid_o), 0);
    chk("rst_ready", -1, {inst_ready_o, data_ready_o}, 0);
    chk("rst_rvalid", -1, {inst_rvalid_o, data_rvalid_o}, 0);
    chk("rst_err", -1, 32'(err_o), 0);
    @(negedge clk);
    idle();
    rst_ni = 1;

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      inst_valid_i = tbl[i].iv;
      inst_addr_i  = tbl[i].ia;
      data_valid_i = tbl[i].dv;
      data_addr_i  = tbl[i].da;
      data_wmask_i = tbl[i].dm;
      mem_ready_i  = tbl[i].mr;
      mem_rvalid_i = tbl[i].rv;
      mem_rdata_i  = tbl[i].rd;
      #1;
      chk("mem_valid", i, 32'(mem_valid_o), 32'(tbl[i].mv));
      if (tbl[i].ca) begin
        chk("mem_addr", i, mem_addr_o, tbl[i].ma);
        chk("mem_wmask", i, 32'(mem_wmask_o), 32'(tbl[i].mm));
      end
      chk("inst_ready", i, 32'(inst_ready_o), 32'(tbl[i].ir));
      chk("data_ready", i, 32'(data_ready_o), 32'(tbl[i].dr));
      chk("inst_rvalid", i, 32'(inst_rvalid_o), 32'(tbl[i].irv));
      chk("data_rvalid", i, 32'(data_rvalid_o), 32'(tbl[i].drv));
      chk("err", i, 32'(err_o), 32'(tbl[i].er));
      chk("rdata_bcast", i, inst_rdata_o ^ data_rdata_o ^ tbl[i].rd,
          tbl[i].rd);
    end

    // Reset with three data requests in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      data_valid_i = 1;
      data_addr_i  = 32'h400 + 32'(4 * k);
      #1;
      chk("fill_ready", k, 32'(data_ready_o), 1);
    end
    @(negedge clk);
    rst_ni       = 0;
    inst_valid_i = 1;
    data_valid_i = 1;
    mem_rvalid_i = 1;
    #1;
    chk("rst2_mem_valid", 0, 32'(mem_valid_o), 0);
    chk("rst2_ready", 0, {inst_ready_o, data_ready_o}, 0);
    chk("rst2_rvalid", 0, {inst_rvalid_o, data_rvalid_o}, 0);
    chk("rst2_err", 0, 32'(err_o), 0);
    @(negedge clk);
    idle();
    rst_ni       = 1;
    mem_rvalid_i = 1;
    #1;
    chk("stray_rvalid", 0, {inst_rvalid_o, data_rvalid_o}, 0);
    chk("stray_err_pre", 0, 32'(err_o), 0);
    @(negedge clk);
    idle();
    #1;
    chk("stray_err_set", 0, 32'(err_o), 1);
    @(negedge clk);
    data_valid_i = 1;
    data_addr_i  = 32'h500;
    data_wdata_i = 32'hdeadbeef;
    data_wmask_i = 4'hf;
    #1;
    chk("fresh_valid", 0, 32'(mem_valid_o), 1);
    chk("fresh_addr", 0, mem_addr_o, 32'h500);
    chk("fresh_wdata", 0, mem_wdata_o, 32'hdeadbeef);
    chk("fresh_ready", 0, {inst_ready_o, data_ready_o}, 1);
    @(negedge clk);
    idle();
    mem_rvalid_i = 1;
    mem_rdata_i  = 32'h1234;
    #1;
    chk("fresh_rvalid", 0, {inst_rvalid_o, data_rvalid_o}, 1);
    chk("fresh_rdata", 0, data_rdata_o, 32'h1234);
    @(negedge clk);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
